// File: rtl/dispatch_buffer_pkg.sv
// Shared types and defaults for the in-order dispatch buffer feeding the R10K core.
package dispatch_buffer_pkg;

    localparam int DISPATCH_N_WAY     = 2;
    localparam int DISPATCH_BUF_DEPTH = 8;

    typedef struct packed {
        logic [31:0] opcode;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic        valid;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/dispatch_buffer_lead_ones.sv
// lead_ones_count: number of consecutive ones in a mask starting at bit 0.
module lead_ones_count #(
    parameter int N = 2
) (
    input  logic [N-1:0]          mask,
    output logic [$clog2(N):0]    count
);

    localparam int CW = $clog2(N) + 1;

    logic run;

    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && mask[i]) begin
                count = CW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order circular buffer between decode and the R10K core; define
// DISPATCH_STALL_CNT_EN to add the stall_cycles counter output.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int N_WAY = DISPATCH_N_WAY,
    parameter int DEPTH = DISPATCH_BUF_DEPTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  DISPATCH_PACKET_R10K [N_WAY-1:0] fetch_packet,
    output logic                            fetch_ready,
    output DISPATCH_PACKET_R10K [N_WAY-1:0] dispatch_packet,
    input  logic [N_WAY-1:0]                dispatched,
    input  logic                            flush,
    output logic [$clog2(DEPTH):0]          buf_count
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]                     stall_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(N_WAY) + 1;

    DISPATCH_PACKET_R10K entries [DEPTH];

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [N_WAY-1:0] lane_valid;
    logic [N_WAY-1:0] fetch_valid;
    logic [LW-1:0]    consumed;
    logic [LW-1:0]    enq_num;
    logic [LW-1:0]    enq_add;
    logic [PW-1:0]    wr_addr [N_WAY];
    logic             enq_en;

    // Readiness looks only at the registered count, so same-cycle dequeues never help.
    assign fetch_ready = (DEPTH - int'(count)) >= N_WAY;
    assign enq_en      = fetch_ready && !flush;
    assign enq_add     = enq_en ? enq_num : '0;
    assign buf_count   = count;

    // Valid fetch lanes are compacted: each lands at tail plus its rank among valid lanes.
    always_comb begin
        enq_num = '0;
        for (int k = 0; k < N_WAY; k++) begin
            fetch_valid[k] = fetch_packet[k].valid;
            wr_addr[k]     = tail + PW'(enq_num);
            if (fetch_packet[k].valid) begin
                enq_num = enq_num + LW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            dispatch_packet[i] = '0;
            lane_valid[i]      = (int'(count) > i) && !flush;
            if (lane_valid[i]) begin
                dispatch_packet[i]       = entries[head + PW'(i)];
                dispatch_packet[i].valid = 1'b1;
            end
        end
    end

    lead_ones_count #(.N(N_WAY)) u_lead_ones (
        .mask  (dispatched & lane_valid),
        .count (consumed)
    );

    always_ff @(posedge clock) begin
        if (enq_en) begin
            for (int k = 0; k < N_WAY; k++) begin
                if (fetch_packet[k].valid) begin
                    entries[wr_addr[k]] <= fetch_packet[k];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(consumed);
            tail  <= tail + PW'(enq_add);
            count <= count + CW'(enq_add) - CW'(consumed);
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    // Counts cycles where the oldest instruction was offered but refused; survives flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (lane_valid[0] && !dispatched[0] && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (int'(count) <= DEPTH)
                else $error("dispatch_buffer: occupancy %0d above depth %0d", count, DEPTH);
            if (!fetch_ready && !flush && (|fetch_valid)) begin
                $warning("dispatch_buffer: fetch lanes offered while not ready, must be held");
            end
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// Randomized and directed bench for dispatch_buffer against a queue-based reference model.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int N = 2;
    localparam int D = 8;

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    DISPATCH_PACKET_R10K [N-1:0]  fetch_packet;
    DISPATCH_PACKET_R10K [N-1:0]  dispatch_packet;
    logic                         fetch_ready;
    logic [N-1:0]                 dispatched;
    logic                         flush;
    logic [$clog2(D):0]           buf_count;
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0]                  stall_cycles;
`endif

    dispatch_buffer #(.N_WAY(N), .DEPTH(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_packet    (fetch_packet),
        .fetch_ready     (fetch_ready),
        .dispatch_packet (dispatch_packet),
        .dispatched      (dispatched),
        .flush           (flush),
        .buf_count       (buf_count)
`ifdef DISPATCH_STALL_CNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int                  checks = 0;
    int                  errors = 0;
    DISPATCH_PACKET_R10K model_q[$];
    int                  stall_model = 0;
    int unsigned         seq = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic fl);
        DISPATCH_PACKET_R10K exp_lane;
        bit                  ready;
        ready = (D - model_q.size()) >= N;
        check("fetch_ready", 64'(fetch_ready), 64'(ready));
        check("buf_count", 64'(buf_count), 64'(model_q.size()));
        for (int i = 0; i < N; i++) begin
            exp_lane = '0;
            if ((model_q.size() > i) && !fl) begin
                exp_lane       = model_q[i];
                exp_lane.valid = 1'b1;
            end
            check($sformatf("lane%0d", i), 64'(dispatch_packet[i]), 64'(exp_lane));
        end
`ifdef DISPATCH_STALL_CNT_EN
        check("stall_cycles", 64'(stall_cycles), 64'(stall_model));
`endif
    endtask

    // One clock: drive at negedge, compare just after, then advance the model at posedge.
    task automatic step(input logic [N-1:0] fv, input logic [N-1:0] disp, input logic fl);
        int consumed;
        bit ready;
        @(negedge clock);
        for (int k = 0; k < N; k++) begin
            fetch_packet[k].opcode = 32'(seq);
            fetch_packet[k].src1   = 5'($urandom);
            fetch_packet[k].src2   = 5'($urandom);
            fetch_packet[k].dest   = 5'($urandom);
            fetch_packet[k].valid  = fv[k];
            seq++;
        end
        dispatched = disp;
        flush      = fl;
        #1;
        check_outputs(fl);
        ready = (D - model_q.size()) >= N;
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else begin
            if ((model_q.size() > 0) && !disp[0]) stall_model++;
            consumed = 0;
            while ((consumed < N) && (consumed < model_q.size()) && disp[consumed]) consumed++;
            repeat (consumed) void'(model_q.pop_front());
            if (ready) begin
                for (int k = 0; k < N; k++) begin
                    if (fv[k]) model_q.push_back(fetch_packet[k]);
                end
            end
        end
    endtask

    initial begin
        logic [N-1:0] fv;
        fetch_packet = '0;
        dispatched   = '0;
        flush        = 1'b0;

        // Reset state while held in reset.
        repeat (2) @(negedge clock);
        #1;
        check_outputs(1'b0);
        reset = 1'b1;

        // Idle after reset release.
        repeat (2) step(2'b00, 2'b00, 1'b0);

        // Fill to 8 with no dispatch; the fifth group must be ignored.
        repeat (5) step(2'b11, 2'b00, 1'b0);
        step(2'b00, 2'b00, 1'b0);

        // Partial accept on A,B,C, then an out-of-order accept that consumes nothing.
        step(2'b00, 2'b00, 1'b1);
        step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        step(2'b00, 2'b10, 1'b0);
        step(2'b00, 2'b00, 1'b0);

        // Sustained enqueue 2 / consume 2 across the pointer wrap.
        repeat (10) step(2'b11, 2'b11, 1'b0);

        // Grow to 6, then enqueue one lane while consuming two.
        repeat (2) step(2'b11, 2'b00, 1'b0);
        step(2'b01, 2'b11, 1'b0);
        step(2'b00, 2'b00, 1'b0);

        // Stalls then flush with activity; the stall count must survive the flush.
        repeat (2) step(2'b00, 2'b00, 1'b0);
        step(2'b11, 2'b11, 1'b1);
        repeat (2) step(2'b00, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a cycle with data buffered.
        repeat (3) step(2'b11, 2'b00, 1'b0);
        @(negedge clock);
        fetch_packet = '0;
        dispatched   = '0;
        flush        = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        stall_model = 0;
        check_outputs(1'b0);
        @(negedge clock);
        reset = 1'b1;
        step(2'b00, 2'b00, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            fv = ((D - model_q.size()) >= N) ? N'($urandom) : '0;
            step(fv, N'($urandom), ($urandom_range(0, 19) == 0));
        end
        step(2'b00, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
